vga_sync_decoder: RTL
=====================

VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- H_TOTAL, 800, clocks per line.
- V_TOTAL, 525, lines per frame.
- H_ACTIVE, 640, display-enable clocks per line.
- V_ACTIVE, 480, active lines per frame.
- SYNC_POL, 0, active level of h_sync_i/v_sync_i.
- LOCK_FRAMES, 2, consecutive good frames needed to lock.

REQ-002 The block SHALL have these ports (name direction width meaning):
- clk  in  1  pixel clock; the only clock.
- arst_n  in  1  reset; asynchronous, active-low.
- h_sync_i  in  1  horizontal sync.
- v_sync_i  in  1  vertical sync.
- de_i  in  1  display enable.
- pix_i  in  12  pixel colour {R[3:0],G[3:0],B[3:0]}.
- clr_err_i  in  1  clears err_o.
- col_o  out  10  recovered column.
- row_o  out  9  recovered row.
- pix_o  out  12  registered pixel colour.
- pix_valid_o  out  1  col_o/row_o/pix_o are a valid active pixel.
- frame_start_o  out  1  one-cycle pulse on each v_sync assertion edge.
- locked_o  out  1  timing locked.
- lock_lost_o  out  1  one-cycle pulse on leaving LOCKED.
- err_o  out  1  sticky timing error.

Function
REQ-003 All inputs SHALL be registered once; an assertion edge is the registered sync changing from inactive to the SYNC_POL level.
- Result: every output is valid one clock after the input sample it describes.
REQ-004 The horizontal counter h_cnt (11 bits) SHALL be:
- cleared on each h_sync assertion edge;
- otherwise incremented, saturating at 2047.
REQ-005 A line is good when h_cnt+1 == H_TOTAL at the h_sync edge and that line had exactly 0 or H_ACTIVE de-high clocks; any other line is bad.
REQ-006 The line counter SHALL:
- count h_sync edges, compare against V_TOTAL at the v_sync edge, then clear;
- when an h_sync edge and a v_sync edge occur in the same cycle, count that h_sync edge in the ending frame.
REQ-007 A frame is good when:
- it contains no bad line;
- line count == V_TOTAL;
- it contains exactly V_ACTIVE lines with de-high clocks.
REQ-008 The state machine SHALL have three states:
- SEARCH: reset state. On a v_sync edge, go to MEASURE with good_cnt=0.
- MEASURE: at each v_sync edge, good_cnt increments on a good frame and clears to 0 on a bad frame. When good_cnt reaches LOCK_FRAMES, go to LOCKED.
- LOCKED: on the first bad line, or a line count exceeding V_TOTAL, go to SEARCH. On that transition, pulse lock_lost_o and set err_o.
REQ-009 In any state other than SEARCH, if no h_sync edge occurs for 2*H_TOTAL clocks, the block SHALL go to SEARCH; if the state was LOCKED, it SHALL also pulse lock_lost_o and set err_o.
REQ-010 locked_o SHALL be 1 exactly while in LOCKED.
REQ-011 col_o SHALL be:
- 0 on the first de-high clock of a line;
- incremented on each further de-high clock, saturating at 1023;
- held when de is low.
REQ-012 row_o SHALL be:
- cleared on each v_sync edge;
- incremented on each de falling edge, saturating at 511.
REQ-013 pix_valid_o SHALL equal registered de AND locked_o.
REQ-014 pix_o SHALL follow the registered pix_i every clock.
REQ-015 frame_start_o SHALL pulse on every v_sync edge, regardless of state.
REQ-016 err_o SHALL:
- be cleared by clr_err_i;
- when clr_err_i and a set condition occur in the same cycle, end that cycle set (set wins).
REQ-017 A coincident de rising edge and h_sync edge SHALL be processed independently; neither suppresses the other.

Reset
REQ-018 While arst_n=0, the block SHALL:
- set state to SEARCH;
- drive all counters, col_o, row_o and pix_o to 0;
- drive pix_valid_o, frame_start_o, locked_o, lock_lost_o and err_o to 0.
REQ-019 Reset asserted mid-frame SHALL abort immediately.
- After release, the block SHALL produce no pix_valid_o until LOCK_FRAMES good frames have been seen following the next v_sync edge.
- Reset asserted while LOCKED SHALL NOT pulse lock_lost_o.

Verification
REQ-020 The bench SHALL cover these directed scenarios (stimulus -> required response):
- Nominal 640x480 timing, 800x525, SYNC_POL=0 -> locked_o rises one clock after the 3rd v_sync edge (SEARCH, then 2 good frames). Then pix_valid_o is high 640 clocks per line, col_o runs 0..639, row_o runs 0..479, and 307200 valid pixels are produced per frame.
- While locked, shorten one line to 799 clocks -> locked_o falls, with lock_lost_o=1 and err_o=1 on the clock after that h_sync edge. Relock occurs after 2 further good frames; err_o stays 1 until clr_err_i.
- Frame with 524 lines during MEASURE -> good_cnt clears, and lock takes 2 more good frames.
- h_sync held inactive for 1600 clocks while locked -> state goes to SEARCH at clock 1600, with lock_lost_o pulsed.
- de held high 700 clocks in one line -> line is bad, col_o reaches 699.
- arst_n pulsed low mid-frame while locked -> all outputs 0 asynchronously, no lock_lost_o pulse, and relock after 3 v_sync edges.
- clr_err_i and an error in the same cycle -> err_o=1 afterwards.

Source files
------------

// File: rtl/vga_sync_decoder.sv
// VGA timing recovery: registers the incoming sync/de/pixel stream, measures line
// and frame geometry, locks after consecutive good frames and recovers col/row.
module vga_sync_decoder #(
  parameter int unsigned H_TOTAL     = 800,
  parameter int unsigned V_TOTAL     = 525,
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned V_ACTIVE    = 480,
  parameter bit          SYNC_POL    = 1'b0,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        h_sync_i,
  input  logic        v_sync_i,
  input  logic        de_i,
  input  logic [11:0] pix_i,
  input  logic        clr_err_i,
  output logic [9:0]  col_o,
  output logic [8:0]  row_o,
  output logic [11:0] pix_o,
  output logic        pix_valid_o,
  output logic        frame_start_o,
  output logic        locked_o,
  output logic        lock_lost_o,
  output logic        err_o
);

  localparam logic [10:0] H_TOT  = 11'(H_TOTAL);
  localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
  localparam logic [10:0] H_WD   = 11'(2 * H_TOTAL - 1);
  localparam logic [9:0]  V_TOT  = 10'(V_TOTAL);
  localparam logic [9:0]  V_ACT  = 10'(V_ACTIVE);
  localparam logic [7:0]  LOCK_N = 8'(LOCK_FRAMES);

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

  state_t      state, state_nx;
  logic [7:0]  good_cnt, good_nx;
  logic        lost_nx, err_nx;

  logic        hs_r, vs_r, de_r, clr_r;
  logic        hs_p, vs_p, de_p, de_q;
  logic [11:0] pix_r;

  logic [10:0] h_cnt, de_cnt;
  logic [9:0]  line_cnt, act_lines;
  logic        frame_bad;

  logic        hs_edge, vs_edge, de_rise, de_fall;
  logic        line_good, line_act, over_v, watchdog, frame_good, bad_eff;
  logic [9:0]  line_inc, act_inc, lines_eff, act_eff;

  // Sync registers idle at the inactive level so release cannot fake an edge.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      hs_r  <= ~SYNC_POL;
      vs_r  <= ~SYNC_POL;
      hs_p  <= ~SYNC_POL;
      vs_p  <= ~SYNC_POL;
      de_r  <= 1'b0;
      de_p  <= 1'b0;
      clr_r <= 1'b0;
      pix_r <= '0;
    end else begin
      hs_r  <= h_sync_i;
      vs_r  <= v_sync_i;
      hs_p  <= hs_r;
      vs_p  <= vs_r;
      de_r  <= de_i;
      de_p  <= de_r;
      clr_r <= clr_err_i;
      pix_r <= pix_i;
    end
  end

  always_comb begin
    hs_edge   = (hs_r == SYNC_POL) && (hs_p != SYNC_POL);
    vs_edge   = (vs_r == SYNC_POL) && (vs_p != SYNC_POL);
    de_rise   = de_r & ~de_p;
    de_fall   = ~de_r & de_p;
    line_act  = (de_cnt != '0);
    line_good = ((h_cnt + 11'd1) == H_TOT) && (!line_act || (de_cnt == H_ACT));
    line_inc  = (line_cnt == '1) ? line_cnt : line_cnt + 10'd1;
    act_inc   = (act_lines == '1) ? act_lines : act_lines + 10'd1;
    // A line ending in the same cycle as the v_sync edge belongs to the ending frame.
    lines_eff = hs_edge ? line_inc : line_cnt;
    act_eff   = (hs_edge && line_act) ? act_inc : act_lines;
    bad_eff   = frame_bad | (hs_edge & ~line_good);
    frame_good = !bad_eff && (lines_eff == V_TOT) && (act_eff == V_ACT);
    over_v    = hs_edge && (line_inc > V_TOT);
    watchdog  = (state != SEARCH) && !hs_edge && (h_cnt >= H_WD);
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state    <= SEARCH;
      good_cnt <= '0;
    end else begin
      state    <= state_nx;
      good_cnt <= good_nx;
    end
  end

  always_comb begin
    state_nx = state;
    good_nx  = good_cnt;
    lost_nx  = 1'b0;
    case (state)
      SEARCH: begin
        if (vs_edge) begin
          state_nx = MEASURE;
          good_nx  = '0;
        end
      end
      MEASURE: begin
        if (watchdog) begin
          state_nx = SEARCH;
        end else if (vs_edge) begin
          if (frame_good) begin
            good_nx = good_cnt + 8'd1;
            if (good_nx >= LOCK_N) state_nx = LOCKED;
          end else begin
            good_nx = '0;
          end
        end
      end
      LOCKED: begin
        if (watchdog || (hs_edge && (!line_good || over_v))) begin
          state_nx = SEARCH;
          lost_nx  = 1'b1;
        end
      end
      default: state_nx = SEARCH;
    endcase
    err_nx = lost_nx ? 1'b1 : (clr_r ? 1'b0 : err_o);
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      h_cnt     <= '0;
      de_cnt    <= '0;
      line_cnt  <= '0;
      act_lines <= '0;
      frame_bad <= 1'b0;
    end else begin
      if (hs_edge) begin
        h_cnt  <= '0;
        de_cnt <= {10'b0, de_r};
      end else begin
        if (h_cnt != '1) h_cnt <= h_cnt + 11'd1;
        if (de_r && de_cnt != '1) de_cnt <= de_cnt + 11'd1;
      end
      if (vs_edge) begin
        line_cnt  <= '0;
        act_lines <= '0;
        frame_bad <= 1'b0;
      end else if (hs_edge) begin
        line_cnt  <= line_inc;
        act_lines <= line_act ? act_inc : act_lines;
        frame_bad <= frame_bad | ~line_good;
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      col_o         <= '0;
      row_o         <= '0;
      pix_o         <= '0;
      de_q          <= 1'b0;
      frame_start_o <= 1'b0;
      lock_lost_o   <= 1'b0;
      err_o         <= 1'b0;
    end else begin
      if (de_rise) col_o <= '0;
      else if (de_r && col_o != '1) col_o <= col_o + 10'd1;
      if (vs_edge) row_o <= '0;
      else if (de_fall && row_o != '1) row_o <= row_o + 9'd1;
      pix_o         <= pix_r;
      de_q          <= de_r;
      frame_start_o <= vs_edge;
      lock_lost_o   <= lost_nx;
      err_o         <= err_nx;
    end
  end

  assign locked_o    = (state == LOCKED);
  assign pix_valid_o = de_q & locked_o;

endmodule
